sr_shifter: RTL and testbench



---
 rtl/sr_shifter.sv | 127 ++++++++++++
 tb/tb_sr_shifter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sr_shifter.sv
// rtl/sr_shifter.sv - serial shifter for a 74HC595-style chain; SR_SHIFTER_LSB_FIRST_EN selects LSB-first order
module sr_shifter #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load,
    input  logic             i_latch,
    output logic             o_busy,
    output logic             o_sck,
    output logic             o_sdo,
    output logic             o_rck
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(DIV + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SETUP, HIGH} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic             load_pend;

`ifdef SR_SHIFTER_LSB_FIRST_EN
    function automatic logic tap(input logic [WIDTH-1:0] w);
        return w[0];
    endfunction
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return w >> 1;
    endfunction
`else
    function automatic logic tap(input logic [WIDTH-1:0] w);
        return w[WIDTH-1];
    endfunction
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return w << 1;
    endfunction
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            load_pend <= 1'b0;
            o_busy    <= 1'b0;
            o_sck     <= 1'b0;
            o_sdo     <= 1'b0;
            o_rck     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (i_latch) begin
                        state  <= LATCH;
                        o_busy <= 1'b1;
                        o_rck  <= 1'b1;
                        if (i_load) begin
                            shreg     <= i_data;
                            load_pend <= 1'b1;
                        end
                    end else if (i_load) begin
                        state  <= SETUP;
                        shreg  <= i_data;
                        o_busy <= 1'b1;
                        o_sdo  <= tap(i_data);
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        o_rck   <= 1'b0;
                        // The pending word was captured at request time, so the RCK pulse latches the previous word
                        if (load_pend) begin
                            load_pend <= 1'b0;
                            state     <= SETUP;
                            bit_cnt   <= '0;
                            o_sdo     <= tap(shreg);
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= HIGH;
                        o_sck   <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                HIGH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        o_sck   <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                            o_sdo  <= 1'b0;
                        end else begin
                            state   <= SETUP;
                            bit_cnt <= bit_cnt + BW'(1);
                            shreg   <= advance(shreg);
                            o_sdo   <= tap(advance(shreg));
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_shifter.sv
// tb/tb_sr_shifter.sv - scoreboard bench for sr_shifter (WIDTH=8, DIV=2)
module tb_sr_shifter;

    localparam int WIDTH = 8;
    localparam int DIV   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] data = '0;
    logic             load = 1'b0;
    logic             latch = 1'b0;
    logic             busy, sck, sdo, rck;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic exp_bits[$];
    int   exp_busy[$];
    int   exp_rck[$];

    sr_shifter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_load(load),
        .i_latch(latch), .o_busy(busy), .o_sck(sck), .o_sdo(sdo), .o_rck(rck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic send_bit(input logic [WIDTH-1:0] w, input int k);
`ifdef SR_SHIFTER_LSB_FIRST_EN
        return w[k];
`else
        return w[WIDTH-1-k];
`endif
    endfunction

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int k = 0; k < WIDTH; k++) exp_bits.push_back(send_bit(w, k));
    endtask

    task automatic issue(input logic [WIDTH-1:0] w, input logic ld, input logic lt);
        @(posedge clk); #1;
        data = w; load = ld; latch = lt;
        @(posedge clk); #1;
        load = 1'b0; latch = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops expected bits on SCK rise, expected pulse lengths on busy/RCK fall
    logic prev_sck = 1'b0, prev_busy = 1'b0, prev_rck = 1'b0, last_sdo = 1'b0;
    int   busy_len = 0, rck_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sck = 1'b0; prev_busy = 1'b0; prev_rck = 1'b0;
            busy_len = 0; rck_len = 0;
        end else begin
            if (sck && !prev_sck) begin
                if (exp_bits.size() == 0) chk("unexpected_sck", 1, 0);
                else chk("sdo_bit", {31'd0, sdo}, {31'd0, exp_bits.pop_front()});
                chk("rck_low_at_sck", {31'd0, rck}, 0);
                last_sdo = sdo;
            end else if (sck) begin
                chk("sdo_hold", {31'd0, sdo}, {31'd0, last_sdo});
            end
            if (busy) busy_len++;
            else if (prev_busy) begin
                if (exp_busy.size() == 0) chk("unexpected_busy", busy_len, 0);
                else chk("busy_len", busy_len, exp_busy.pop_front());
                busy_len = 0;
            end
            if (rck) rck_len++;
            else if (prev_rck) begin
                if (exp_rck.size() == 0) chk("unexpected_rck", rck_len, 0);
                else chk("rck_len", rck_len, exp_rck.pop_front());
                rck_len = 0;
            end
            prev_sck = sck; prev_busy = busy; prev_rck = rck;
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {28'd0, busy, sck, sdo, rck}, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outputs", {28'd0, busy, sck, sdo, rck}, 0);
        end

        // plain load
        push_word(8'hA5); exp_busy.push_back(2 * DIV * WIDTH);
        issue(8'hA5, 1'b1, 1'b0);
        wait_idle();
        chk("sdo_after_a5", {31'd0, sdo}, 0);

        // latch alone
        exp_busy.push_back(DIV); exp_rck.push_back(DIV);
        issue(8'h00, 1'b0, 1'b1);
        wait_idle();

        // latch with load
        push_word(8'h3C); exp_busy.push_back(DIV + 2 * DIV * WIDTH); exp_rck.push_back(DIV);
        issue(8'h3C, 1'b1, 1'b1);
        wait_idle();

        // load while busy is ignored
        push_word(8'hFF); exp_busy.push_back(2 * DIV * WIDTH);
        issue(8'hFF, 1'b1, 1'b0);
        repeat (8) @(posedge clk);
        issue(8'h00, 1'b1, 1'b0);
        wait_idle();

        // reset mid-shift after third SCK rise
        push_word(8'h81); exp_busy.push_back(2 * DIV * WIDTH);
        issue(8'h81, 1'b1, 1'b0);
        for (int n = 0; n < 100 && exp_bits.size() > WIDTH - 3; n++) begin
            @(negedge clk); #2;
        end
        chk("third_rise_seen", exp_bits.size(), WIDTH - 3);
        rst_n = 1'b0;
        exp_bits.delete(); exp_busy.delete();
        #1;
        chk("abort_outputs", {28'd0, busy, sck, sdo, rck}, 0);
        repeat (3) @(negedge clk);
        chk("abort_held", {28'd0, busy, sck, sdo, rck}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {28'd0, busy, sck, sdo, rck}, 0);

        push_word(8'h01); exp_busy.push_back(2 * DIV * WIDTH);
        issue(8'h01, 1'b1, 1'b0);
        wait_idle();

        chk("bits_drained", exp_bits.size(), 0);
        chk("busy_drained", exp_busy.size(), 0);
        chk("rck_drained", exp_rck.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
